instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the MIPS core. Owns the program counter, drives the word address of the synchronous-read instruction ROM (one-cycle read latency, no read enable), absorbs the ROM latency with a two-entry output buffer, and presents {instruction, PC, PC+4} to decode over a valid/ready handshake. It also accepts branch and jump redirects from downstream.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
- ADDR_W, 13, width of the instruction-memory word address.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_imem_addr  out  ADDR_W  word address to instruction memory; read data is valid on i_imem_rd one cycle later.
- i_imem_rd  in  32  instruction memory read data.
- i_redirect  in  1  branch/jump taken; flushes the stage.
- i_redirect_pc  in  32  redirect target byte address; bits [1:0] are ignored.
- o_valid  out  1  o_instr/o_pc/o_pc_plus4 hold a valid instruction.
- i_ready  in  1  decode accepts the instruction this cycle.
- o_instr  out  32  fetched instruction.
- o_pc  out  32  byte address of o_instr.
- o_pc_plus4  out  32  o_pc + 4, modulo 2^32.

## Operation
- State:
  - pc_q: next byte address to issue.
  - inflight_v/inflight_pc: a read was issued last cycle, and its data is on i_imem_rd this cycle.
  - out register: out_v, instr, pc.
  - skid register: skid_v, instr, pc.
- o_imem_addr = i_redirect ? i_redirect_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2]. This is the only combinational output. The ROM wraps every 2^(ADDR_W+2) bytes.
- pop = o_valid && i_ready.
- Issue condition: (out_v + skid_v + inflight_v − pop) < 2, or i_redirect. On issue:
  - inflight_v <= 1.
  - inflight_pc <= the issued address, with bits [1:0] = 0.
  - pc_q <= that address + 4.
- No issue: inflight_v <= 0 and pc_q holds. The address stays driven, and the returning data is ignored.
- Data arrival (inflight_v = 1, no redirect):
  - The entry goes to the out register if the out register is empty or being popped and the skid register is empty.
  - Otherwise it goes to the skid register.
  - Program order is always preserved.
- Pop with skid_v = 1: the skid entry moves to the out register. The arriving entry, if any, goes to the skid register.
- Redirect (highest priority, over i_ready and data arrival):
  - An instruction popped in the redirect cycle counts as accepted.
  - out_v, skid_v and the arriving data are discarded.
  - The target is issued in the same cycle.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32.
- Never possible: the skid register full while the out register is empty; an instruction presented twice; an instruction lost.

## Timing
- Reset (i_rst = 1 at an edge):
  - pc_q = RESET_PC; out_v = skid_v = inflight_v = 0.
  - o_valid = 0, o_instr = 0, o_pc = 0, o_pc_plus4 = 4.
  - While i_rst is high, o_imem_addr = RESET_PC[ADDR_W+1:2].
- Reset asserted mid-operation overrides everything. o_valid = 0 in the cycle after the edge, and fetch restarts at RESET_PC.
- Startup:
  - Cycle 0 is the first cycle with i_rst = 0; RESET_PC is issued.
  - Cycle 1: data arrives.
  - Cycle 2: o_valid = 1 with o_pc = RESET_PC.
- Throughput is 1 instruction/cycle while i_ready = 1.
- Redirect latency: redirect asserted in cycle t gives o_valid = 1 with o_pc = target in cycle t+2, and o_valid = 0 in cycle t+1. The penalty is 1 bubble.
- Stall:
  - While o_valid && !i_ready, the outputs hold stable.
  - At most 2 instructions are buffered, and issue stops.
  - When i_ready rises, the next instruction appears the following cycle with no bubble, because the skid register is full.
- Outputs o_valid, o_instr, o_pc and o_pc_plus4 are registered.

## Test plan
- Basic stream: reset with RESET_PC = 0, mem[k] = 32'h100 + k, i_ready = 1. o_valid rises in cycle 2 after reset release, then o_pc = 0, 4, 8, … every cycle with o_instr = 0x100, 0x101, 0x102, ….
- Stall: drop i_ready for 3 cycles while o_valid = 1 at o_pc = 0x8. The outputs hold 0x8/0x102. After release, o_pc = 0x8, 0xC, 0x10 on consecutive cycles, with no gaps or duplicates.
- Redirect during stall: with the skid register full, pulse i_redirect with i_redirect_pc = 0x40. o_valid = 0 the next cycle, then o_pc = 0x40 / o_instr = 0x110, and the stale buffered entries never appear.
- Misaligned redirect: i_redirect_pc = 0x43. o_imem_addr = 0x10 in the same cycle, and o_pc = 0x40, o_pc_plus4 = 0x44.
- Wrap: redirect to 0x7FFC. o_imem_addr = 0x1FFF, then 0x0000. o_pc = 0x7FFC, then 0x8000, with o_instr = mem[0x1FFF], then mem[0].
- Reset mid-stream: assert i_rst for 1 cycle with o_valid = 1 and the skid register full. o_valid = 0 the next cycle, then the stream restarts at o_pc = RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : MIPS instruction fetch stage. Owns the PC, addresses a
//                synchronous-read instruction ROM, hides the one-cycle ROM
//                latency with an out/skid buffer pair and presents
//                {instr, pc, pc+4} to decode over valid/ready. Accepts
//                branch/jump redirects, which flush the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rd,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4
);

    localparam logic [ADDR_W-1:0] c_reset_waddr = RESET_PC[ADDR_W+1:2];

    // Fetch pointer and the read currently returning from the ROM
    logic [31:0] r_pc_q;
    logic        r_inflight_v;
    logic [31:0] r_inflight_pc;

    // Output register (what decode sees) and the skid entry behind it
    logic        r_out_v;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc_plus4;
    logic        r_skid_v;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        w_pop;
    logic [1:0]  w_count;
    logic        w_issue;
    logic [31:0] w_issue_addr;

    // Issue decision: keep at most two entries owned by the stage, counting
    // the one still in the ROM; a redirect always issues its target.
    always_comb begin
        w_pop        = r_out_v & i_ready;
        w_count      = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_inflight_v};
        w_issue      = i_redirect | ((w_count - {1'b0, w_pop}) < 2'd2);
        w_issue_addr = i_redirect ? (i_redirect_pc & ~32'd3) : r_pc_q;
        o_imem_addr  = i_rst ? c_reset_waddr : w_issue_addr[ADDR_W+1:2];
    end

    // Fetch pointer, in-flight tracking and out/skid buffer movement
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc_q         <= RESET_PC;
            r_inflight_v   <= 1'b0;
            r_inflight_pc  <= 32'd0;
            r_out_v        <= 1'b0;
            r_out_instr    <= 32'd0;
            r_out_pc       <= 32'd0;
            r_out_pc_plus4 <= 32'd4;
            r_skid_v       <= 1'b0;
            r_skid_instr   <= 32'd0;
            r_skid_pc      <= 32'd0;
        end else begin
            r_inflight_v <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= w_issue_addr;
                r_pc_q        <= w_issue_addr + 32'd4;
            end

            if (i_redirect) begin
                // Everything buffered or returning belongs to the old path
                r_out_v  <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_pop) begin
                if (r_skid_v) begin
                    // Skid entry is older than any arriving data
                    r_out_instr    <= r_skid_instr;
                    r_out_pc       <= r_skid_pc;
                    r_out_pc_plus4 <= r_skid_pc + 32'd4;
                    if (r_inflight_v) begin
                        r_skid_instr <= i_imem_rd;
                        r_skid_pc    <= r_inflight_pc;
                    end else begin
                        r_skid_v <= 1'b0;
                    end
                end else if (r_inflight_v) begin
                    r_out_instr    <= i_imem_rd;
                    r_out_pc       <= r_inflight_pc;
                    r_out_pc_plus4 <= r_inflight_pc + 32'd4;
                end else begin
                    r_out_v <= 1'b0;
                end
            end else if (r_inflight_v) begin
                if (!r_out_v) begin
                    // Skid is necessarily empty when the out register is
                    r_out_v        <= 1'b1;
                    r_out_instr    <= i_imem_rd;
                    r_out_pc       <= r_inflight_pc;
                    r_out_pc_plus4 <= r_inflight_pc + 32'd4;
                end else begin
                    // Issue throttling guarantees the skid slot is free here
                    r_skid_v     <= 1'b1;
                    r_skid_instr <= i_imem_rd;
                    r_skid_pc    <= r_inflight_pc;
                end
            end
        end
    end

    assign o_valid    = r_out_v;
    assign o_instr    = r_out_instr;
    assign o_pc       = r_out_pc;
    assign o_pc_plus4 = r_out_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch with a
//                synchronous-read ROM model where mem[k] = 32'h100 + k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int ADDR_W = 13;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rd;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              valid;
    logic              ready;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (ADDR_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_rd     (imem_rd),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM, one-cycle latency
    always @(posedge clk) imem_rd <= 32'h100 + {19'd0, imem_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, ".valid"}, {31'd0, valid}, 32'd1);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".instr"}, instr, exp_instr);
        check({tag, ".pc4"}, pc_plus4, exp_pc + 32'd4);
    endtask

    initial begin
        rst         = 1'b1;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        next_cycle();
        next_cycle();
        // Reset state
        check("rst.valid", {31'd0, valid}, 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.pc", pc, 32'd0);
        check("rst.pc4", pc_plus4, 32'd4);
        check("rst.addr", {19'd0, imem_addr}, 32'd0);

        // Basic stream: cycle 0 after release
        rst = 1'b0;
        #1;
        check("c0.addr", {19'd0, imem_addr}, 32'd0);
        check("c0.valid", {31'd0, valid}, 32'd0);
        next_cycle();
        check("c1.valid", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("c2", 32'h0, 32'h100);
        next_cycle();
        check_out("c3", 32'h4, 32'h101);
        next_cycle();
        check_out("c4", 32'h8, 32'h102);

        // Stall three cycles at pc 0x8
        ready = 1'b0;
        next_cycle();
        check_out("stall1", 32'h8, 32'h102);
        next_cycle();
        check_out("stall2", 32'h8, 32'h102);
        next_cycle();
        check_out("stall3", 32'h8, 32'h102);
        ready = 1'b1;
        next_cycle();
        check_out("rel.c", 32'hC, 32'h103);
        next_cycle();
        check_out("rel.10", 32'h10, 32'h104);

        // Fill the skid register, then redirect to 0x40
        ready = 1'b0;
        next_cycle();
        check_out("skid.hold", 32'h10, 32'h104);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rd.addr", {19'd0, imem_addr}, 32'h10);
        next_cycle();
        redirect = 1'b0;
        ready    = 1'b1;
        check("rd.bubble", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("rd.t2", 32'h40, 32'h110);
        next_cycle();
        check_out("rd.t3", 32'h44, 32'h111);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        #1;
        check("mis.addr", {19'd0, imem_addr}, 32'h10);
        next_cycle();
        redirect = 1'b0;
        check("mis.bubble", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("mis.t2", 32'h40, 32'h110);

        // ROM address wrap
        redirect    = 1'b1;
        redirect_pc = 32'h7FFC;
        #1;
        check("wrap.addr0", {19'd0, imem_addr}, 32'h1FFF);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("wrap.addr1", {19'd0, imem_addr}, 32'h0);
        check("wrap.bubble", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("wrap.t2", 32'h7FFC, 32'h20FF);
        next_cycle();
        check_out("wrap.t3", 32'h8000, 32'h100);

        // Reset mid-stream with the skid register full
        ready = 1'b0;
        next_cycle();
        check_out("mrst.hold", 32'h8000, 32'h100);
        rst = 1'b1;
        next_cycle();
        rst   = 1'b0;
        ready = 1'b1;
        #1;
        check("mrst.valid", {31'd0, valid}, 32'd0);
        check("mrst.pc4", pc_plus4, 32'd4);
        check("mrst.addr", {19'd0, imem_addr}, 32'd0);
        next_cycle();
        check("mrst.c1", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("mrst.c2", 32'h0, 32'h100);
        next_cycle();
        check_out("mrst.c3", 32'h4, 32'h101);

        // 32-bit PC wrap on pc+4
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        check("pcw.bubble", {31'd0, valid}, 32'd0);
        next_cycle();
        check_out("pcw.t2", 32'hFFFF_FFFC, 32'h20FF);
        check("pcw.pc4", pc_plus4, 32'h0);
        next_cycle();
        check_out("pcw.t3", 32'h0, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
